// File: rtl/piezo_tone_decoder_if.sv
// Tone-in bundle between a tone source and the decoder: enable and tone line in, note/period out.
// Ports: enable, tone_in (source side); note, note_valid, note_change, period (decoder side).
// Modports: master = source/observer, slave = piezo_tone_decoder.
interface piezo_tone_decoder_if;
    logic        enable;
    logic        tone_in;
    logic [7:0]  note;
    logic        note_valid;
    logic        note_change;
    logic [12:0] period;

    modport master (
        output enable,
        output tone_in,
        input  note,
        input  note_valid,
        input  note_change,
        input  period
    );

    modport slave (
        input  enable,
        input  tone_in,
        output note,
        output note_valid,
        output note_change,
        output period
    );
endinterface

// File: rtl/piezo_tone_decoder.sv
// Recovers the one-hot note code C2..C3 from a square-wave tone by period measurement.
// Latency: state/note/period update 2 clocks after tone_in is first sampled high; lock needs 3 rising edges.
// No backpressure: tone_in is free-running; outputs are registered levels plus a one-cycle change pulse.
// Ports: clock, reset (async, active-high); bus (slave modport): enable, tone_in in; note,
//        note_valid, note_change, period out.
module piezo_tone_decoder #(
    parameter int TIMEOUT = 4200
) (
    input  logic                 clock,
    input  logic                 reset,
    piezo_tone_decoder_if.slave  bus
);

    localparam logic [12:0] CNT_MAX = 13'h1FFF;
    localparam logic [12:0] TO_VAL  = 13'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        CAND = 2'd2,
        LOCK = 2'd3
    } state_t;

    state_t      state, state_n;
    logic        s1, s2, s2_d;
    logic        rise;
    logic [12:0] cnt;
    logic [12:0] period_q;
    logic        seen;
    logic [7:0]  note_q, note_n;
    logic [7:0]  cand, cand_n;
    logic        valid_q, change_q;
    logic [7:0]  cls;
    logic        cls_ok;

    // Window edges sit midway between neighbouring generator periods.
    function automatic logic [7:0] classify(input logic [12:0] p);
        logic [7:0] c;
        c = 8'h00;
        if      (p >= 13'd3617 && p <= 13'd4095) c = 8'h01;
        else if (p >= 13'd3221 && p <= 13'd3616) c = 8'h02;
        else if (p >= 13'd2953 && p <= 13'd3220) c = 8'h04;
        else if (p >= 13'd2709 && p <= 13'd2952) c = 8'h08;
        else if (p >= 13'd2413 && p <= 13'd2708) c = 8'h10;
        else if (p >= 13'd2152 && p <= 13'd2412) c = 8'h20;
        else if (p >= 13'd1972 && p <= 13'd2151) c = 8'h40;
        else if (p >= 13'd1800 && p <= 13'd1971) c = 8'h80;
        return c;
    endfunction

    assign rise   = s2 & ~s2_d;
    assign cls    = classify(cnt);
    assign cls_ok = |cls;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= bus.tone_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // Loaded with 1 on an edge so that its value at the next edge equals the period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= 13'd0;
        end else if (!bus.enable) begin
            cnt <= 13'd0;
        end else if (rise) begin
            cnt <= 13'd1;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 13'd1;
        end
    end

    // The first edge after reset/enable has no preceding edge, so it reports no period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen     <= 1'b0;
            period_q <= 13'd0;
        end else if (!bus.enable) begin
            seen     <= 1'b0;
        end else if (rise) begin
            seen     <= 1'b1;
            if (seen) begin
                period_q <= cnt;
            end
        end
    end

    always_comb begin
        state_n = state;
        note_n  = note_q;
        cand_n  = cand;
        if (!bus.enable) begin
            state_n = IDLE;
            note_n  = 8'h00;
            cand_n  = 8'h00;
        end else if (rise) begin
            // An edge takes priority over a coincident timeout.
            case (state)
                IDLE: state_n = ARM;
                ARM: begin
                    if (cls_ok) begin
                        state_n = CAND;
                        cand_n  = cls;
                    end
                end
                CAND: begin
                    if (!cls_ok) begin
                        state_n = ARM;
                    end else if (cls == cand) begin
                        state_n = LOCK;
                        note_n  = cls;
                    end else begin
                        cand_n  = cls;
                    end
                end
                LOCK: begin
                    if (!cls_ok) begin
                        state_n = ARM;
                        note_n  = 8'h00;
                    end else if (cls != note_q) begin
                        // Old note holds until the new one is confirmed twice.
                        state_n = CAND;
                        cand_n  = cls;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && cnt == TO_VAL) begin
            state_n = IDLE;
            note_n  = 8'h00;
            cand_n  = 8'h00;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            note_q   <= 8'h00;
            cand     <= 8'h00;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state    <= state_n;
            note_q   <= note_n;
            cand     <= cand_n;
            valid_q  <= |note_n;
            change_q <= (note_n != note_q);
        end
    end

    assign bus.note        = note_q;
    assign bus.note_valid  = valid_q;
    assign bus.note_change = change_q;
    assign bus.period      = period_q;

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Directed bench for piezo_tone_decoder: lock, note switch, timeout, invalid periods, reset, enable.
// Tone is driven on falling clock edges; outputs are checked on falling edges, away from the active edge.
// Ports: bench owns the interface (master side) plus clock/reset.
module tb_piezo_tone_decoder;

    localparam int TIMEOUT = 4200;

    logic clock;
    logic reset;
    int   n_asserts;
    int   n_fail;
    int   chg_count;

    piezo_tone_decoder_if bus ();

    piezo_tone_decoder #(.TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.note_change === 1'b1) chg_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One full tone period (h high, h low) starting with a rising edge on the current falling clock edge.
    // The rise lands in note/period three falling edges later.
    task automatic tone_period(input string tag, input int h, input logic [7:0] pre,
                               input logic [7:0] post, input logic chg, input int exp_p);
        bus.tone_in = 1'b1;
        repeat (2) @(negedge clock);
        chk({tag, "_note_before"}, 32'(bus.note), 32'(pre));
        @(negedge clock);
        chk({tag, "_note"}, 32'(bus.note), 32'(post));
        chk({tag, "_valid"}, 32'(bus.note_valid), 32'(post != 8'h00));
        chk({tag, "_change"}, 32'(bus.note_change), 32'(chg));
        if (exp_p >= 0) chk({tag, "_period"}, 32'(bus.period), 32'(exp_p));
        @(negedge clock);
        chk({tag, "_change_next"}, 32'(bus.note_change), 32'd0);
        repeat (h - 4) @(negedge clock);
        bus.tone_in = 1'b0;
        repeat (h) @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        chg_count   = 0;
        reset       = 1'b1;
        bus.enable  = 1'b1;
        bus.tone_in = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_note",   32'(bus.note),        32'd0);
        chk("rst_valid",  32'(bus.note_valid),  32'd0);
        chk("rst_change", 32'(bus.note_change), 32'd0);
        chk("rst_period", 32'(bus.period),      32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Steady C2, then switch to C3.
        tone_period("c2_e1", 1916, 8'h00, 8'h00, 1'b0, 0);
        tone_period("c2_e2", 1916, 8'h00, 8'h00, 1'b0, 3832);
        tone_period("c2_e3", 1916, 8'h00, 8'h01, 1'b1, 3832);
        chk("c2_pulses_lock", 32'(chg_count), 32'd1);
        tone_period("c2_e4", 1916, 8'h01, 8'h01, 1'b0, 3832);
        tone_period("c3_e1", 957,  8'h01, 8'h01, 1'b0, 3832);
        tone_period("c3_e2", 957,  8'h01, 8'h01, 1'b0, 1914);
        chk("c2_hold_pulses", 32'(chg_count), 32'd1);
        tone_period("c3_e3", 957,  8'h01, 8'h80, 1'b1, 1914);
        chk("c3_pulses", 32'(chg_count), 32'd2);

        // G2 lock, then silence until timeout.
        pulse_reset();
        tone_period("g2_e1", 1276, 8'h00, 8'h00, 1'b0, -1);
        tone_period("g2_e2", 1276, 8'h00, 8'h00, 1'b0, 2552);
        tone_period("g2_e3", 1276, 8'h00, 8'h10, 1'b1, 2552);
        repeat (TIMEOUT + 2 - 2 * 1276) @(negedge clock);
        chk("g2_before_timeout", 32'(bus.note), 32'h10);
        @(negedge clock);
        chk("g2_timeout_note",   32'(bus.note),        32'h00);
        chk("g2_timeout_valid",  32'(bus.note_valid),  32'd0);
        chk("g2_timeout_change", 32'(bus.note_change), 32'd1);
        chk("g2_timeout_idle",   32'(dut.state),       32'd0);
        @(negedge clock);
        chk("g2_timeout_change_next", 32'(bus.note_change), 32'd0);

        // Out-of-range periods never lock.
        tone_period("p1500_e1", 750, 8'h00, 8'h00, 1'b0, -1);
        tone_period("p1500_e2", 750, 8'h00, 8'h00, 1'b0, 1500);
        tone_period("p1500_e3", 750, 8'h00, 8'h00, 1'b0, 1500);
        tone_period("p1500_e4", 750, 8'h00, 8'h00, 1'b0, 1500);
        tone_period("p4500_e1", 2250, 8'h00, 8'h00, 1'b0, 1500);
        tone_period("p4500_e2", 2250, 8'h00, 8'h00, 1'b0, 4500);

        // Alternating A2/B2 keeps replacing the candidate.
        tone_period("ab_e1", 1137, 8'h00, 8'h00, 1'b0, 4500);
        tone_period("ab_e2", 1015, 8'h00, 8'h00, 1'b0, 2274);
        tone_period("ab_e3", 1137, 8'h00, 8'h00, 1'b0, 2030);
        tone_period("ab_e4", 1015, 8'h00, 8'h00, 1'b0, 2274);

        // E2 lock, asynchronous reset mid-period, relock.
        pulse_reset();
        tone_period("e2_e1", 1520, 8'h00, 8'h00, 1'b0, 0);
        tone_period("e2_e2", 1520, 8'h00, 8'h00, 1'b0, 3040);
        tone_period("e2_e3", 1520, 8'h00, 8'h04, 1'b1, 3040);
        bus.tone_in = 1'b1;
        repeat (500) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_note",   32'(bus.note),        32'd0);
        chk("arst_valid",  32'(bus.note_valid),  32'd0);
        chk("arst_change", 32'(bus.note_change), 32'd0);
        chk("arst_period", 32'(bus.period),      32'd0);
        @(negedge clock);
        bus.tone_in = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tone_period("e2r_e1", 1520, 8'h00, 8'h00, 1'b0, 0);
        tone_period("e2r_e2", 1520, 8'h00, 8'h00, 1'b0, 3040);
        tone_period("e2r_e3", 1520, 8'h00, 8'h04, 1'b1, 3040);

        // Enable drop while locked, then no lock while disabled.
        bus.enable = 1'b0;
        @(negedge clock);
        chk("en_off_note",   32'(bus.note),        32'd0);
        chk("en_off_valid",  32'(bus.note_valid),  32'd0);
        chk("en_off_change", 32'(bus.note_change), 32'd1);
        @(negedge clock);
        chk("en_off_change_next", 32'(bus.note_change), 32'd0);
        tone_period("en_off_e1", 957, 8'h00, 8'h00, 1'b0, -1);
        tone_period("en_off_e2", 957, 8'h00, 8'h00, 1'b0, -1);
        tone_period("en_off_e3", 957, 8'h00, 8'h00, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
